// File: rtl/spi_master_seq.sv
// Command-driven SPI master: turns one host command into one SS_n-framed SPI transfer,
// returning the MISO byte for read-data frames.
module spi_master_seq #(
   parameter int RD_WAIT = 2,
   parameter int GAP     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_payload,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       err
);

   // state   | meaning
   // S_IDLE  | waiting for a command, cmd_ready high
   // S_START | SS_n asserted, MOSI low
   // S_CMD   | read/write select bit on MOSI
   // S_SHIFT | 10-bit frame word {op, payload}, MSB first
   // S_WAIT  | slave turnaround before read data
   // S_RECV  | 8 MISO bits sampled MSB first
   // S_END   | SS_n high for GAP cycles, response strobe on first cycle
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_CMD, S_SHIFT, S_WAIT, S_RECV, S_END
   } state_t;

   localparam int CW = 8;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [9:0]    frame;
   logic [1:0]    op_q;
   logic [7:0]    shreg;
   logic          rd_addr_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         frame        <= '0;
         op_q         <= '0;
         shreg        <= '0;
         rd_addr_pend <= 1'b0;
         SS_n         <= 1'b1;
         MOSI         <= 1'b0;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         err          <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         err       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  if (cmd_op == 2'b11 && !rd_addr_pend) begin
                     err <= 1'b1;
                  end else begin
                     frame     <= {cmd_op, cmd_payload};
                     op_q      <= cmd_op;
                     state     <= S_START;
                     SS_n      <= 1'b0;
                     MOSI      <= 1'b0;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            S_START: begin
               state <= S_CMD;
               MOSI  <= op_q[1];
            end
            S_CMD: begin
               state <= S_SHIFT;
               MOSI  <= frame[9];
               cnt   <= CW'(9);
            end
            S_SHIFT: begin
               if (cnt == '0) begin
                  MOSI <= 1'b0;
                  if (op_q == 2'b11) begin
                     state <= S_WAIT;
                     cnt   <= CW'(RD_WAIT - 1);
                  end else begin
                     state <= S_END;
                     SS_n  <= 1'b1;
                     cnt   <= CW'(GAP - 1);
                     if (op_q == 2'b10) rd_addr_pend <= 1'b1;
                  end
               end else begin
                  // frame shifts left so frame[8] is always the next bit out
                  MOSI  <= frame[8];
                  frame <= {frame[8:0], 1'b0};
                  cnt   <= cnt - 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state <= S_RECV;
                  cnt   <= CW'(7);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RECV: begin
               shreg <= {shreg[6:0], MISO};
               if (cnt == '0) begin
                  state        <= S_END;
                  SS_n         <= 1'b1;
                  rsp_data     <= {shreg[6:0], MISO};
                  rsp_valid    <= 1'b1;
                  rd_addr_pend <= 1'b0;
                  cnt          <= CW'(GAP - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_END: begin
               if (cnt == '0) begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               SS_n      <= 1'b1;
               MOSI      <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_seq.sv
// Directed + randomized bench for spi_master_seq; a frame-level model predicts SS_n/MOSI timing,
// responses and errors, and a pin-level slave supplies MISO bytes.
module tb_spi_master_seq;
   localparam int RW = 2;
   localparam int GP = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_payload;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       busy;
   logic       err;

   int         checks = 0;
   int         errors = 0;
   bit         pend;
   logic [7:0] exp_rsp;
   logic [7:0] slave_byte;
   int         lowcnt = 0;

   spi_master_seq #(.RD_WAIT(RW), .GAP(GP)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_payload(cmd_payload), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // slave: counts SS_n-low cycles and drives the read byte during the receive window
   always @(negedge clk) begin
      if (SS_n === 1'b0) lowcnt = lowcnt + 1;
      else lowcnt = 0;
      if (lowcnt >= 13 + RW && lowcnt <= 20 + RW) MISO = slave_byte[7 - (lowcnt - 13 - RW)];
      else MISO = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [7:0] pl, input logic [7:0] sb,
                         input bit hold, input int abort_at);
      int         len;
      bit         ok;
      bit         is_err;
      bit         chkm;
      logic       em;
      logic [9:0] f;
      f          = {op, pl};
      slave_byte = sb;
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_payload = pl;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) ok = 1'b1;
      end
      chk("accept_ready", 32'(ok), 1);
      if (!ok) return;
      chk("idle_rsp_hold", rsp_data, exp_rsp);
      chk("idle_ss_n", SS_n, 1);
      chk("idle_busy", busy, 0);
      @(posedge clk);
      #1;
      is_err      = (op == 2'b11) && !pend;
      cmd_valid   = hold && !is_err;
      cmd_op      = 2'($urandom);
      cmd_payload = 8'($urandom);
      if (is_err) begin
         @(negedge clk);
         chk("err_pulse", err, 1);
         chk("err_ss_n", SS_n, 1);
         chk("err_rsp_valid", rsp_valid, 0);
         chk("err_ready", cmd_ready, 1);
         chk("err_busy", busy, 0);
         @(negedge clk);
         chk("err_one_cycle", err, 0);
         chk("err_no_frame", SS_n, 1);
         return;
      end
      len = (op == 2'b11) ? 20 + RW : 12;
      for (int k = 1; k <= len + GP; k++) begin
         @(negedge clk);
         if (k == abort_at) begin
            cmd_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("rst_ss_n", SS_n, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ready", cmd_ready, 1);
            chk("rst_mosi", MOSI, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            pend    = 1'b0;
            exp_rsp = 8'h00;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         chk("ss_n", SS_n, (k <= len) ? 0 : 1);
         chkm = 1'b1;
         if (k == 1) em = 1'b0;
         else if (k == 2) em = op[1];
         else if (k <= 12) begin
            em   = f[12 - k];
            chkm = (op != 2'b11);
         end else em = 1'b0;
         if (chkm) chk("mosi", MOSI, em);
         chk("busy", busy, 1);
         chk("ready_busy", cmd_ready, 0);
         chk("no_err", err, 0);
         chk("rsp_valid", rsp_valid, (op == 2'b11 && k == len + 1) ? 1 : 0);
         if (op == 2'b11 && k == len + 1) chk("rsp_data", rsp_data, sb);
      end
      if (op == 2'b10) pend = 1'b1;
      if (op == 2'b11) begin
         pend    = 1'b0;
         exp_rsp = sb;
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b00;
      cmd_payload = 8'h00;
      pend        = 1'b0;
      exp_rsp     = 8'h00;
      slave_byte  = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_ss_n", SS_n, 1);
      chk("reset_mosi", MOSI, 0);
      chk("reset_ready", cmd_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_err", err, 0);
      rst_n = 1'b1;

      do_cmd(2'b11, 8'h00, 8'h00, 1'b0, 0);
      do_cmd(2'b00, 8'h3C, 8'h00, 1'b0, 0);
      do_cmd(2'b01, 8'hA5, 8'h00, 1'b0, 0);
      do_cmd(2'b10, 8'h3C, 8'h00, 1'b0, 0);
      do_cmd(2'b11, 8'h00, 8'hA5, 1'b0, 0);
      do_cmd(2'b11, 8'h00, 8'h5A, 1'b0, 0);
      do_cmd(2'b10, 8'h11, 8'h00, 1'b0, 0);
      do_cmd(2'b10, 8'h22, 8'h00, 1'b0, 0);
      do_cmd(2'b11, 8'hFF, 8'hC3, 1'b0, 0);

      do_cmd(2'b10, 8'h44, 8'h00, 1'b0, 0);
      do_cmd(2'b00, 8'h96, 8'h00, 1'b0, 6);
      do_cmd(2'b11, 8'h00, 8'h77, 1'b0, 0);

      for (int n = 0; n < 40; n++)
         do_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b1, 0);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("final_idle_ss_n", SS_n, 1);
      chk("final_ready", cmd_ready, 1);
      chk("final_rsp_hold", rsp_data, exp_rsp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
